// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access stage: RAMCtrl access types, FSM states,
// byte-enable patterns and the access legality check.
package mem_access_unit_pkg;

  localparam logic [2:0] RC_FULL   = 3'd0;
  localparam logic [2:0] RC_FULLX  = 3'd1;
  localparam logic [2:0] RC_HALF   = 3'd2;
  localparam logic [2:0] RC_HALFX  = 3'd3;
  localparam logic [2:0] RC_HALFU  = 3'd4;
  localparam logic [2:0] RC_HALFUX = 3'd5;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } mau_state_e;

  // 1 when the access type is undefined or the address is not naturally aligned.
  function automatic logic access_fault(input logic [2:0] ctrl, input logic [1:0] alo);
    case (ctrl)
      RC_FULL, RC_FULLX:                      return (alo != 2'b00);
      RC_HALF, RC_HALFX, RC_HALFU, RC_HALFUX: return alo[0];
      default:                                return 1'b1;
    endcase
  endfunction

  function automatic logic is_swapped(input logic [2:0] ctrl);
    return (ctrl == RC_FULLX) || (ctrl == RC_HALFX) || (ctrl == RC_HALFUX);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// RAM-side bus of the memory access stage.
// Handshake: master raises ram_req for one cycle with ram_we/ram_be/ram_addr/ram_wdata
// stable and holds them until the slave returns a one-cycle ram_ack (ram_rdata valid with it).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ram_req;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational store lane placement / byte enables and
// load halfword selection, byte swap and sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  st_ctrl,
  input  logic        st_hi,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  input  logic [2:0]  ld_ctrl,
  input  logic        ld_hi,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [15:0] st_half;
  logic [15:0] ld_half_raw;
  logic [15:0] ld_half;
  logic [31:0] st_rev;
  logic [31:0] ld_rev;

  always_comb begin
    st_rev  = {st_data[7:0], st_data[15:8], st_data[23:16], st_data[31:24]};
    st_half = is_swapped(st_ctrl) ? {st_data[7:0], st_data[15:8]} : st_data[15:0];
    st_be   = 4'b0000;
    st_word = 32'h0;
    case (st_ctrl)
      RC_FULL: begin
        st_be   = BE_WORD;
        st_word = st_data;
      end
      RC_FULLX: begin
        st_be   = BE_WORD;
        st_word = st_rev;
      end
      RC_HALF, RC_HALFX, RC_HALFU, RC_HALFUX: begin
        st_be   = st_hi ? BE_HI : BE_LO;
        st_word = st_hi ? {st_half, 16'h0} : {16'h0, st_half};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_rev      = {ld_word[7:0], ld_word[15:8], ld_word[23:16], ld_word[31:24]};
    ld_half_raw = ld_hi ? ld_word[31:16] : ld_word[15:0];
    ld_half     = is_swapped(ld_ctrl) ? {ld_half_raw[7:0], ld_half_raw[15:8]} : ld_half_raw;
    ld_data     = 32'h0;
    case (ld_ctrl)
      RC_FULL:              ld_data = ld_word;
      RC_FULLX:             ld_data = ld_rev;
      RC_HALF, RC_HALFX:    ld_data = {{16{ld_half[15]}}, ld_half};
      RC_HALFU, RC_HALFUX:  ld_data = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: turns controller MemRead/MemWrite into one RAM bus transaction
// and stalls the CPU via MIO_ready. Optional WAIT timeout: define MEMACC_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        RAMCtrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              MIO_ready,
  output logic [31:0]       rdata,
  output logic              mem_err,
  mem_access_unit_if.master ram,
  output mau_state_e        state_dbg
);

  mau_state_e  state;
  logic        go;
  logic [2:0]  ctrl_q;
  logic        hi_q;
  logic [3:0]  st_be;
  logic [31:0] st_word;
  logic [31:0] ld_data;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef MEMACC_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  assign go        = MemRead | MemWrite;
  assign state_dbg = state;

  mem_lane_align u_lane (
    .st_ctrl (RAMCtrl),
    .st_hi   (addr[1]),
    .st_data (wdata),
    .st_be   (st_be),
    .st_word (st_word),
    .ld_ctrl (ctrl_q),
    .ld_hi   (hi_q),
    .ld_word (ram.ram_rdata),
    .ld_data (ld_data)
  );

  // IDLE answers combinationally so the controller stalls in the request cycle itself.
  always_comb begin
    MIO_ready = 1'b0;
    case (state)
      ST_IDLE:          MIO_ready = !go;
      ST_DONE, ST_HOLD: MIO_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rdata         <= 32'h0;
      mem_err       <= 1'b0;
      ram.ram_req   <= 1'b0;
      ram.ram_we    <= 1'b0;
      ram.ram_be    <= 4'b0000;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= 32'h0;
      ctrl_q        <= RC_FULL;
      hi_q          <= 1'b0;
`ifdef MEMACC_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (access_fault(RAMCtrl, addr[1:0])) begin
              mem_err <= 1'b1;
              state   <= ST_DONE;
            end else begin
              ram.ram_req   <= 1'b1;
              ram.ram_we    <= MemWrite;
              ram.ram_be    <= st_be;
              ram.ram_addr  <= {addr[ADDR_W-1:2], 2'b00};
              ram.ram_wdata <= st_word;
              ctrl_q        <= RAMCtrl;
              hi_q          <= addr[1];
`ifdef MEMACC_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          ram.ram_req <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ram.ram_ack) begin
            if (!ram.ram_we) rdata <= ld_data;
            state <= ST_DONE;
          end
`ifdef MEMACC_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: state <= ST_HOLD;
        ST_HOLD: if (!go) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses, bus/response scoreboard, reset and error cases.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  RAMCtrl = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        MIO_ready;
  logic [31:0] rdata;
  logic        mem_err;
  mau_state_e  st_dbg;

  mem_access_unit_if #(.ADDR_W(32)) ram_bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RAMCtrl   (RAMCtrl),
    .addr      (addr),
    .wdata     (wdata),
    .MIO_ready (MIO_ready),
    .rdata     (rdata),
    .mem_err   (mem_err),
    .ram       (ram_bus),
    .state_dbg (st_dbg)
  );

  int checks = 0;
  int errors = 0;

  // {we, be, addr, wdata} per bus request; {mem_err, rdata} per completion
  logic [68:0] exp_bus_q[$];
  logic [32:0] exp_rsp_q[$];

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (ram_bus.ram_req) begin
        if (exp_bus_q.size() == 0) chk("bus_unexpected", 69'd1, 69'd0);
        else chk("bus", {ram_bus.ram_we, ram_bus.ram_be, ram_bus.ram_addr, ram_bus.ram_wdata},
                 exp_bus_q.pop_front());
      end
      if (st_dbg == ST_DONE) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 69'd1, 69'd0);
        else chk("rsp", {36'h0, mem_err, rdata}, {36'h0, exp_rsp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ram_bus.ram_ack = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // ack_dly = cycles from ram_req to ram_ack; 0 = never ack
  task automatic run_acc(input string nm, input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] raw,
                         input int ack_dly, input int hold, input int exp_lows,
                         output int pulses);
    int lows, dly_cnt;
    logic seen_req, acked, done;
    lows = 0; dly_cnt = 0; seen_req = 1'b0; acked = 1'b0; done = 1'b0; pulses = 0;
    @(posedge clk); #2;
    MemRead = rd; MemWrite = wr; RAMCtrl = ctrl; addr = a; wdata = wd;
    #1;
    for (int c = 0; c < 40; c++) begin
      ram_bus.ram_ack = 1'b0;
      if (MIO_ready) begin
        done = 1'b1;
        break;
      end
      lows++;
      if (ram_bus.ram_req) begin
        seen_req = 1'b1;
        dly_cnt = 0;
      end else if (seen_req && !acked) begin
        dly_cnt++;
        if (dly_cnt == ack_dly) begin
          ram_bus.ram_ack = 1'b1;
          ram_bus.ram_rdata = raw;
          acked = 1'b1;
        end
      end
      @(posedge clk); #3;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout act=stalled exp=MIO_ready", nm);
    end
    chk({nm, "_stall"}, 69'(lows), 69'(exp_lows));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #3;
      if (ram_bus.ram_req) pulses++;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
  endtask

  int p;

  initial begin
    ram_bus.ram_ack = 1'b0;
    ram_bus.ram_rdata = 32'h0;
    #12;
    // reset state
    chk("rst_ready", 69'(MIO_ready), 69'd1);
    chk("rst_rdata", 69'(rdata), 69'd0);
    chk("rst_err", 69'(mem_err), 69'd0);
    chk("rst_bus", {ram_bus.ram_req, ram_bus.ram_we, ram_bus.ram_be, ram_bus.ram_addr, ram_bus.ram_wdata}, 69'd0);
    chk("rst_state", 69'(st_dbg), 69'(ST_IDLE));
    @(posedge clk); #2; rst = 1'b1;

    // loads
    exp_bus_q.push_back({1'b0, 4'hF, 32'h100, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h11223344});
    run_acc("ld_full", 1, 0, RC_FULL, 32'h100, 0, 32'h11223344, 2, 0, 4, p);
    exp_bus_q.push_back({1'b0, 4'hC, 32'h100, 32'h0}); exp_rsp_q.push_back({1'b0, 32'hFFFF8001});
    run_acc("ld_half", 1, 0, RC_HALF, 32'h102, 0, 32'h80017FFF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b0, 4'hC, 32'h100, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h00008001});
    run_acc("ld_halfu", 1, 0, RC_HALFU, 32'h102, 0, 32'h80017FFF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b0, 4'h3, 32'h100, 32'h0}); exp_rsp_q.push_back({1'b0, 32'hFFFFFF80});
    run_acc("ld_halfx", 1, 0, RC_HALFX, 32'h100, 0, 32'h000080FF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h104, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h44332211});
    run_acc("ld_fullx", 1, 0, RC_FULLX, 32'h104, 0, 32'h11223344, 3, 0, 5, p);
    exp_bus_q.push_back({1'b0, 4'hC, 32'h104, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("ld_halfux", 1, 0, RC_HALFUX, 32'h106, 0, 32'h01FE0000, 1, 0, 3, p);

    // stores (rdata must not change)
    exp_bus_q.push_back({1'b1, 4'hC, 32'h204, 32'hCDAB0000}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("st_halfx", 0, 1, RC_HALFX, 32'h206, 32'h0000ABCD, 32'hFFFFFFFF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b1, 4'hF, 32'h300, 32'hDEADBEEF}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("st_full", 0, 1, RC_FULL, 32'h300, 32'hDEADBEEF, 32'hFFFFFFFF, 2, 0, 4, p);
    exp_bus_q.push_back({1'b1, 4'hF, 32'h304, 32'h04030201}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("st_fullx", 0, 1, RC_FULLX, 32'h304, 32'h01020304, 32'hFFFFFFFF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b1, 4'h3, 32'h400, 32'h0000A5A5}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("st_half", 0, 1, RC_HALF, 32'h400, 32'h5555A5A5, 32'hFFFFFFFF, 1, 0, 3, p);
    exp_bus_q.push_back({1'b1, 4'hC, 32'h400, 32'h12340000}); exp_rsp_q.push_back({1'b0, 32'h0000FE01});
    run_acc("rdwr_is_wr", 1, 1, RC_HALF, 32'h402, 32'h00001234, 32'hFFFFFFFF, 1, 0, 3, p);

    // request held high: one transaction only, then a fresh one after drop
    exp_bus_q.push_back({1'b0, 4'hF, 32'h500, 32'h0}); exp_rsp_q.push_back({1'b0, 32'hCAFEF00D});
    run_acc("hold", 1, 0, RC_FULL, 32'h500, 0, 32'hCAFEF00D, 1, 10, 3, p);
    chk("hold_pulses", 69'(p), 69'd0);
    exp_bus_q.push_back({1'b0, 4'hF, 32'h504, 32'h0}); exp_rsp_q.push_back({1'b0, 32'h0BADBEEF});
    run_acc("reissue", 1, 0, RC_FULL, 32'h504, 0, 32'h0BADBEEF, 1, 0, 3, p);

    // errors: no bus transaction
    exp_rsp_q.push_back({1'b1, 32'h0BADBEEF});
    run_acc("misalign_full", 1, 0, RC_FULL, 32'h101, 0, 32'h0, 1, 0, 1, p);
    chk("err_sticky", 69'(mem_err), 69'd1);
    do_reset();
    chk("err_cleared", 69'(mem_err), 69'd0);
    exp_rsp_q.push_back({1'b1, 32'h0});
    run_acc("illegal_ctrl", 1, 0, 3'd7, 32'h100, 0, 32'h0, 1, 0, 1, p);
    do_reset();
    exp_rsp_q.push_back({1'b1, 32'h0});
    run_acc("misalign_half", 1, 0, RC_HALF, 32'h103, 0, 32'h0, 1, 0, 1, p);
    chk("err_no_latch", 69'(ram_bus.ram_be), 69'd0);
    do_reset();

    // reset during REQ: ram_req drops asynchronously
    @(posedge clk); #2;
    MemRead = 1'b1; RAMCtrl = RC_FULL; addr = 32'h600; wdata = 32'h0;
    @(posedge clk); #2;
    chk("req_before_rst", 69'(ram_bus.ram_req), 69'd1);
    rst = 1'b0; #1;
    chk("req_async_drop", 69'(ram_bus.ram_req), 69'd0);
    chk("req_rst_state", 69'(st_dbg), 69'(ST_IDLE));
    MemRead = 1'b0;
    @(posedge clk); #2; rst = 1'b1;

    // reset during WAIT, then a late ack: no capture
    @(posedge clk); #2;
    exp_bus_q.push_back({1'b0, 4'hF, 32'h600, 32'h0});
    MemRead = 1'b1; RAMCtrl = RC_FULL; addr = 32'h600;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("wait_state", 69'(st_dbg), 69'(ST_WAIT));
    rst = 1'b0; #1;
    chk("wait_rst_state", 69'(st_dbg), 69'(ST_IDLE));
    ram_bus.ram_ack = 1'b1; ram_bus.ram_rdata = 32'hFFFFFFFF;
    @(posedge clk); #2;
    ram_bus.ram_ack = 1'b0; MemRead = 1'b0; rst = 1'b1;
    @(posedge clk); #2;
    ram_bus.ram_ack = 1'b1;
    @(posedge clk); #2;
    ram_bus.ram_ack = 1'b0;
    chk("wait_rst_rdata", 69'(rdata), 69'd0);
    chk("wait_rst_err", 69'(mem_err), 69'd0);
    chk("wait_rst_idle", 69'(st_dbg), 69'(ST_IDLE));
    chk("wait_rst_ready", 69'(MIO_ready), 69'd1);

`ifdef MEMACC_TIMEOUT_EN
    // no ack: abort after 5 WAIT cycles
    exp_bus_q.push_back({1'b0, 4'hF, 32'h700, 32'h0}); exp_rsp_q.push_back({1'b1, 32'h0});
    run_acc("timeout", 1, 0, RC_FULL, 32'h700, 0, 32'h0, 0, 0, 7, p);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("bus_q_empty", 69'(exp_bus_q.size()), 69'd0);
    chk("rsp_q_empty", 69'(exp_rsp_q.size()), 69'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-side stage directly downstream of the multi-cycle MIPS controller. It consumes MemRead/MemWrite/RAMCtrl and the IorD-selected address plus store data, runs a req/ack transaction on the external RAM bus, and generates byte enables and store-data lane placement. It sign- or zero-extends load data into a 32-bit result for the MDR. It drives MIO_ready back to the controller so the CPU stalls until the access finishes.

Parameters:
ADDR_W, 32, width of the byte address on both the CPU side and the RAM side.
TIMEOUT_CYC, 255, cycles to wait in WAIT before aborting; used only with MEMACC_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
MemRead  in  1  load request from controller (level).
MemWrite  in  1  store request from controller (level).
RAMCtrl  in  3  access type: Full=0, Fullx=1, Half=2, Halfx=3, Halfu=4, Halfux=5; 6 and 7 are illegal.
addr  in  ADDR_W  byte address (ALU_out).
wdata  in  32  store data (register B).
MIO_ready  out  1  1 = CPU may proceed; 0 = suspend.
rdata  out  32  extended load result, held until next load completes.
mem_err  out  1  sticky misalign/illegal/timeout flag.
ram_req  out  1  bus request.
ram_we  out  1  1 = write.
ram_be  out  4  byte enables.
ram_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00).
ram_wdata  out  32  lane-placed store data.
ram_ack  in  1  one-cycle completion strobe from RAM.
ram_rdata  in  32  read word, valid with ram_ack.

Behaviour:
- Reset (rst=0, async): state=IDLE; MIO_ready=1; rdata=0; mem_err=0; ram_req=0; ram_we=0; ram_be=0; ram_addr=0; ram_wdata=0.
- Request rule: go = MemRead|MemWrite. If both are high, it is a write.
- States: IDLE, REQ, WAIT, DONE, HOLD.
- IDLE: MIO_ready=!go (combinational, so the controller stalls in the same cycle). On go:
  - Illegal RAMCtrl, or misalignment (Full/Fullx with addr[1:0]!=0; Half* with addr[0]=1): set mem_err and go to DONE. No bus transaction.
  - Otherwise latch addr, type, we and lane data, then go to REQ.
- REQ: ram_req=1 for exactly one cycle, with all bus outputs stable, then go to WAIT.
- WAIT: ram_req=0. Bus outputs are held. On ram_ack, capture the extended read data (loads only) and go to DONE.
- DONE: MIO_ready=1 for one cycle, then go to HOLD.
- HOLD: MIO_ready=1. Return to IDLE once go=0. A request held high never starts a second transaction.
- Latency: a request seen in cycle 0 drives ram_req in cycle 1. An ack in cycle k gives MIO_ready=1 in cycle k+1. Minimum 3 cycles with zero-wait RAM (ack in cycle 2).
- Byte enables:
  - Full: 1111.
  - Half, addr[1]=0: 0011 with data in bits [15:0].
  - Half, addr[1]=1: 1100 with data in bits [31:16].
- x variants are byte-reversed (big-endian) accesses:
  - Fullx stores and loads {b0,b1,b2,b3}.
  - Halfx/Halfux swap the two bytes of the selected halfword.
- Loads: select the halfword lane by addr[1], swap bytes if x, then extend. Half/Halfx sign-extend; Halfu/Halfux zero-extend; Full/Fullx pass through.
- ram_ack outside WAIT is ignored.
- mem_err clears only on reset.
- Reset mid-transaction aborts immediately. ram_req drops asynchronously and no capture occurs.

Optional Feature:
MEMACC_TIMEOUT_EN
- Defined: an 8-bit-min counter (width clog2(TIMEOUT_CYC+1)) runs in WAIT. When it reaches TIMEOUT_CYC without ram_ack:
  - set mem_err;
  - leave rdata unchanged;
  - go to DONE so the CPU is not deadlocked.
  - The counter clears on entry to REQ.
- Undefined: no counter logic; WAIT waits indefinitely for ram_ack.

Decomposition:
- Shared package/header (alongside the existing MIPS parameter header) holds:
  - RAMCtrl encodings (Full..Halfux);
  - state encodings for this FSM;
  - byte-enable constants BE_WORD, BE_LO, BE_HI.
- One natural sub-module, mem_lane_align: purely combinational. It handles store lane placement and byte swap, byte-enable generation, and load extraction/extension. This keeps the FSM file free of data-path muxing.

Test Plan:
- MemRead, Full, addr=0x100, ram_ack 2 cycles after ram_req, ram_rdata=0x11223344 -> ram_be=1111, ram_addr=0x100, rdata=0x11223344, MIO_ready low 4 cycles.
- MemRead, Half, addr=0x102, ram_rdata=0x8001_7FFF -> rdata=0xFFFF8001; repeat with Halfu -> 0x00008001.
- MemWrite, Halfx, addr=0x206, wdata=0x0000ABCD -> ram_we=1, ram_be=1100, ram_wdata[31:16]=0xCDAB, ram_addr=0x204.
- MemRead, Full, addr=0x101 -> no ram_req, mem_err=1, MIO_ready returns 1 after DONE; RAMCtrl=7 behaves identically.
- Hold MemRead high for 10 cycles after completion -> exactly one ram_req pulse; drop and reassert -> a second transaction.
- Reset asserted while in WAIT, then ram_ack arrives -> ram_req=0 at once, rdata stays 0, state IDLE. With MEMACC_TIMEOUT_EN and TIMEOUT_CYC=5 and no ack -> mem_err=1 after 5 WAIT cycles, then MIO_ready=1.
